// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops show-ahead FIFO words and serialises them
// as start / DATA_WIDTH data bits (LSB first) / STOP_BITS stop bits, back-to-back while data remains.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    bit_end;
  logic                    pop;

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    tx_done = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        pop = ~empty;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            tx_done = 1'b1;
            if (empty) state_d = S_IDLE;
            else       pop     = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop restarts the frame from the show-ahead head word, with no idle gap.
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      idx_d   = '0;
      shreg_d = rd_data;
    end

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // The FIFO must never see a pop while the transmitter is held in reset.
  assign rd      = pop & reset;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: behavioural FIFO feeds the DUT, a frame monitor
// decodes tx and compares each frame against a scoreboard of bytes written to the FIFO.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int FRAME2 = 11 * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Depth-4 FIFO model for the main DUT.
  logic [7:0] mem [4];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       empty;
  logic [7:0] rd_data;
  logic       rd, tx, tx_busy, tx_done;

  assign empty   = (wr_cnt == rd_cnt);
  assign rd_data = mem[rd_cnt[1:0]];
  always @(posedge clk) if (rd) rd_cnt <= rd_cnt + 1;

  // Single-word feed for the two-stop-bit instance.
  int         wr2_cnt = 0;
  int         rd2_cnt = 0;
  logic [7:0] rd_data2 = 8'h00;
  logic       empty2;
  logic       rd2, tx2, tx_busy2, tx_done2;

  assign empty2 = (wr2_cnt == rd2_cnt);
  always @(posedge clk) if (rd2) rd2_cnt <= rd2_cnt + 1;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .empty(empty), .rd_data(rd_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .empty(empty2), .rd_data(rd_data2),
    .rd(rd2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb [$];
  int         mon_k = 0;
  bit         in_frame = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #2;
    mem[wr_cnt[1:0]] = b;
    sb.push_back(b);
    wr_cnt++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((tx_busy || in_frame || wr_cnt != rd_cnt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  // Watches every pop, samples the whole frame and compares it with the scoreboard head.
  task automatic monitor_loop();
    bit chain = 1'b0;
    forever begin
      if (!chain) @(negedge clk);
      chain = 1'b0;
      if (reset && rd) begin
        logic [7:0] exp_b   = 8'h00;
        logic [7:0] got_b   = 8'h00;
        logic [9:0] fr;
        int         bit_err  = 0;
        int         rd_err   = 0;
        int         done_err = 0;
        int         busy_err = 0;
        bit         aborted  = 1'b0;
        logic       rd_last  = 1'b0;
        logic       rd_want  = 1'b0;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else                exp_b = sb.pop_front();
        fr       = {1'b1, exp_b, 1'b0};
        in_frame = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
          int j;
          @(negedge clk);
          mon_k = k;
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          j = (k - 1) / CPB;
          if (tx !== fr[j]) bit_err++;
          if ((j >= 1) && (j <= 8) && ((k - 1) % CPB == 1)) got_b[j-1] = tx;
          if (tx_done !== (k == FRAME)) done_err++;
          if (tx_busy !== 1'b1) busy_err++;
          if ((k < FRAME) && (rd !== 1'b0)) rd_err++;
          if (k == FRAME) begin
            rd_last = rd;
            rd_want = (wr_cnt != rd_cnt);
          end
        end
        in_frame = 1'b0;
        mon_k    = 0;
        if (!aborted) begin
          check("frame_byte", got_b, exp_b);
          check("frame_bit_errs", bit_err, 0);
          check("tx_done_pos_errs", done_err, 0);
          check("tx_busy_errs", busy_err, 0);
          check("early_rd_errs", rd_err, 0);
          check("b2b_rd", rd_last, rd_want);
          chain = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    int rd_hits;
    int tx_lows;
    fork
      monitor_loop();
    join_none

    // 1: held in reset with the FIFO pre-loaded.
    push(8'h3C);
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rd", rd, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_tx2", tx2, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_idle("t1_idle", 200);

    // 2: single byte into an idle FIFO.
    r0 = rd_cnt;
    push(8'hA5);
    @(negedge clk);
    wait_idle("t2_idle", 200);
    check("t2_rd_count", rd_cnt - r0, 1);
    check("t2_busy_low", tx_busy, 0);
    check("t2_tx_idle", tx, 1);

    // 3: four queued bytes, expect contiguous frames.
    r0 = rd_cnt;
    for (int i = 1; i <= 4; i++) push(8'(i));
    @(negedge clk);
    wait_idle("t3_idle", 400);
    check("t3_rd_count", rd_cnt - r0, 4);
    check("t3_busy_low", tx_busy, 0);

    // 4: FIFO stays empty.
    rd_hits = 0;
    tx_lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd !== 1'b0) rd_hits++;
      if (tx !== 1'b1) tx_lows++;
    end
    check("t4_rd_hits", rd_hits, 0);
    check("t4_tx_lows", tx_lows, 0);

    // 5: reset during data bit 3 of 0x55; the following byte must go out instead.
    r0 = rd_cnt;
    push(8'h55);
    n = 0;
    while (mon_k != 18 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_bit3", 32'(n < 200), 1);
    #1 reset = 1'b0;
    #1;
    check("t5_async_tx", tx, 1);
    check("t5_async_busy", tx_busy, 0);
    push(8'h66);
    repeat (3) @(negedge clk);
    check("t5_rd_in_reset", rd, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    wait_idle("t5_idle", 300);
    check("t5_rd_count", rd_cnt - r0, 2);

    // 6: two stop bits, byte 0xFF.
    @(posedge clk);
    #2;
    rd_data2 = 8'hFF;
    wr2_cnt++;
    n = 0;
    while (rd2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_pop_seen", 32'(n < 20), 1);
    begin
      int bit_err  = 0;
      int done_err = 0;
      int busy_err = 0;
      for (int k = 1; k <= FRAME2; k++) begin
        @(negedge clk);
        if (tx2 !== (k > CPB)) bit_err++;
        if (tx_done2 !== (k == FRAME2)) done_err++;
        if (tx_busy2 !== 1'b1) busy_err++;
      end
      check("t6_bit_errs", bit_err, 0);
      check("t6_done_pos_errs", done_err, 0);
      check("t6_busy_errs", busy_err, 0);
    end
    @(negedge clk);
    check("t6_busy_low", tx_busy2, 0);
    check("t6_rd_count", rd2_cnt, 1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
